// File: rtl/adc_trigger_capture.sv
// Trigger-and-capture stage behind the ADC. It keeps a circular record of
// pre- and post-trigger samples and replays the record in chronological order.
module adc_trigger_capture #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 10
) (
    input  logic              ADC_CLK,
    input  logic              ADC_RST,
    input  logic [DATA_W-1:0] ADC_DATA,
    input  logic              ARM,
    input  logic              FORCE_TRIG,
    input  logic [DATA_W-1:0] TRIG_LEVEL,
    input  logic              TRIG_EDGE,
    input  logic [ADDR_W-1:0] PRE_TRIG,
    input  logic              RD_EN,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              RD_VALID,
    output logic              RD_LAST,
    output logic              CAP_BUSY,
    output logic              CAP_DONE,
    output logic              TRIGGERED
);

    localparam int N = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    typedef enum logic [2:0] {IDLE, PRETRIG, WAIT_TRIG, POSTTRIG, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [N];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] p_lat;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_k;
    logic [DATA_W-1:0] prev;
    logic              prev_ok;

    logic              capturing;
    logic              hit_rise;
    logic              hit_fall;
    logic              trig_fire;
    logic [ADDR_W-1:0] trig_start;

    assign capturing  = (state == PRETRIG) || (state == WAIT_TRIG) || (state == POSTTRIG);
    assign hit_rise   = (prev < TRIG_LEVEL) && (ADC_DATA >= TRIG_LEVEL);
    assign hit_fall   = (prev >= TRIG_LEVEL) && (ADC_DATA < TRIG_LEVEL);
    assign trig_fire  = FORCE_TRIG || (prev_ok && (TRIG_EDGE ? hit_fall : hit_rise));
    assign trig_start = wr_ptr - p_lat;

    // Buffer write port has no reset so it maps onto block RAM.
    always_ff @(posedge ADC_CLK) begin
        if (!ADC_RST && capturing) begin
            mem[wr_ptr] <= ADC_DATA;
        end
    end

    always_ff @(posedge ADC_CLK) begin
        if (ADC_RST) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            cnt        <= '0;
            p_lat      <= '0;
            start_addr <= '0;
            rd_ptr     <= '0;
            rd_k       <= '0;
            prev       <= '0;
            prev_ok    <= 1'b0;
            RD_DATA    <= '0;
            RD_VALID   <= 1'b0;
            RD_LAST    <= 1'b0;
            CAP_BUSY   <= 1'b0;
            CAP_DONE   <= 1'b0;
            TRIGGERED  <= 1'b0;
        end else begin
            RD_VALID <= 1'b0;
            RD_LAST  <= 1'b0;
            if (capturing) begin
                wr_ptr  <= wr_ptr + ONE;
                prev    <= ADC_DATA;
                prev_ok <= 1'b1;
            end
            case (state)
                IDLE, DONE: begin
                    // ARM takes priority over a simultaneous readout request.
                    if (ARM) begin
                        wr_ptr    <= '0;
                        cnt       <= '0;
                        p_lat     <= PRE_TRIG;
                        prev_ok   <= 1'b0;
                        TRIGGERED <= 1'b0;
                        CAP_BUSY  <= 1'b1;
                        CAP_DONE  <= 1'b0;
                        state     <= (PRE_TRIG != '0) ? PRETRIG : WAIT_TRIG;
                    end else if (state == DONE && RD_EN) begin
                        RD_DATA  <= mem[rd_ptr];
                        RD_VALID <= 1'b1;
                        RD_LAST  <= (rd_k == LAST_IDX);
                        rd_ptr   <= (rd_k == LAST_IDX) ? start_addr : rd_ptr + ONE;
                        rd_k     <= rd_k + ONE;
                    end
                end
                PRETRIG: begin
                    cnt <= cnt + ONE;
                    if (cnt == p_lat - ONE) begin
                        state <= WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    if (trig_fire) begin
                        start_addr <= trig_start;
                        TRIGGERED  <= 1'b1;
                        cnt        <= '0;
                        if (p_lat != LAST_IDX) begin
                            state <= POSTTRIG;
                        end else begin
                            state    <= DONE;
                            rd_ptr   <= trig_start;
                            rd_k     <= '0;
                            CAP_BUSY <= 1'b0;
                            CAP_DONE <= 1'b1;
                        end
                    end
                end
                POSTTRIG: begin
                    cnt <= cnt + ONE;
                    // The post-trigger phase fills the remaining N-1-P slots.
                    if (cnt == LAST_IDX - ONE - p_lat) begin
                        state    <= DONE;
                        rd_ptr   <= start_addr;
                        rd_k     <= '0;
                        CAP_BUSY <= 1'b0;
                        CAP_DONE <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_trigger_capture.sv
// Self-checking bench for adc_trigger_capture (ADDR_W=4). A record-level model
// treats the final record as the last N captured samples and is checked every cycle.
module tb_adc_trigger_capture;

    localparam int DATA_W = 14;
    localparam int ADDR_W = 4;
    localparam int N      = 16;

    logic              ADC_CLK;
    logic              ADC_RST;
    logic [DATA_W-1:0] ADC_DATA;
    logic              ARM;
    logic              FORCE_TRIG;
    logic [DATA_W-1:0] TRIG_LEVEL;
    logic              TRIG_EDGE;
    logic [ADDR_W-1:0] PRE_TRIG;
    logic              RD_EN;
    logic [DATA_W-1:0] RD_DATA;
    logic              RD_VALID;
    logic              RD_LAST;
    logic              CAP_BUSY;
    logic              CAP_DONE;
    logic              TRIGGERED;

    adc_trigger_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .ADC_CLK   (ADC_CLK),
        .ADC_RST   (ADC_RST),
        .ADC_DATA  (ADC_DATA),
        .ARM       (ARM),
        .FORCE_TRIG(FORCE_TRIG),
        .TRIG_LEVEL(TRIG_LEVEL),
        .TRIG_EDGE (TRIG_EDGE),
        .PRE_TRIG  (PRE_TRIG),
        .RD_EN     (RD_EN),
        .RD_DATA   (RD_DATA),
        .RD_VALID  (RD_VALID),
        .RD_LAST   (RD_LAST),
        .CAP_BUSY  (CAP_BUSY),
        .CAP_DONE  (CAP_DONE),
        .TRIGGERED (TRIGGERED)
    );

    initial begin
        ADC_CLK = 1'b0;
        forever #5 ADC_CLK = ~ADC_CLK;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef enum {M_IDLE, M_CAPT, M_DONE} mphase_t;

    mphase_t m_phase;
    int      m_p;
    int      m_post_left;
    int      m_rd_k;
    bit      m_trig;
    bit      m_prev_valid;
    int      m_prev;
    int      m_hist[$];
    int      m_rec[N];
    int      exp_rdata;
    bit      exp_valid;
    bit      exp_last;

    int      n_checks;
    int      n_errors;
    int      read_log[$];
    int      last_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic model_start();
        m_phase      = M_CAPT;
        m_p          = int'(PRE_TRIG);
        m_hist.delete();
        m_trig       = 1'b0;
        m_prev_valid = 1'b0;
    endtask

    // The finished record is simply the most recent N samples captured.
    task automatic model_finish();
        for (int k = 0; k < N; k++) begin
            m_rec[k] = m_hist[m_hist.size() - N + k];
        end
        m_rd_k  = 0;
        m_phase = M_DONE;
    endtask

    task automatic model_step();
        int d;
        int lvl;
        bit hit;
        exp_valid = 1'b0;
        exp_last  = 1'b0;
        d   = int'(ADC_DATA);
        lvl = int'(TRIG_LEVEL);
        if (ADC_RST) begin
            m_phase      = M_IDLE;
            m_trig       = 1'b0;
            m_prev_valid = 1'b0;
            exp_rdata    = 0;
        end else begin
            case (m_phase)
                M_IDLE: if (ARM) model_start();
                M_DONE: begin
                    if (ARM) begin
                        model_start();
                    end else if (RD_EN) begin
                        exp_rdata = m_rec[m_rd_k];
                        exp_valid = 1'b1;
                        exp_last  = (m_rd_k == N - 1);
                        m_rd_k    = (m_rd_k + 1) % N;
                    end
                end
                default: begin
                    m_hist.push_back(d);
                    if (!m_trig) begin
                        if (m_hist.size() > m_p) begin
                            if (TRIG_EDGE == 1'b0) hit = m_prev_valid && (m_prev < lvl) && (d >= lvl);
                            else                   hit = m_prev_valid && (m_prev >= lvl) && (d < lvl);
                            if (FORCE_TRIG || hit) begin
                                m_trig      = 1'b1;
                                m_post_left = N - 1 - m_p;
                                if (m_post_left == 0) model_finish();
                            end
                        end
                    end else begin
                        m_post_left--;
                        if (m_post_left == 0) model_finish();
                    end
                    m_prev       = d;
                    m_prev_valid = 1'b1;
                end
            endcase
        end
    endtask

    task automatic checkOutput();
        check("CAP_BUSY", 32'(CAP_BUSY), 32'(m_phase == M_CAPT));
        check("CAP_DONE", 32'(CAP_DONE), 32'(m_phase == M_DONE));
        check("TRIGGERED", 32'(TRIGGERED), 32'(m_trig));
        check("RD_VALID", 32'(RD_VALID), 32'(exp_valid));
        check("RD_LAST", 32'(RD_LAST), 32'(exp_last));
        check("RD_DATA", 32'(RD_DATA), 32'(exp_rdata));
        if (RD_VALID) begin
            read_log.push_back(int'(RD_DATA));
            if (RD_LAST) last_idx = read_log.size() - 1;
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit arm, input bit force_t,
                                 input bit rd, input logic [DATA_W-1:0] data);
        @(negedge ADC_CLK);
        ADC_RST    = rst;
        ARM        = arm;
        FORCE_TRIG = force_t;
        RD_EN      = rd;
        ADC_DATA   = data;
        @(posedge ADC_CLK);
        model_step();
        #1;
        checkOutput();
    endtask

    function automatic logic [DATA_W-1:0] gen_data(input int kind, input int i);
        case (kind)
            0:       return DATA_W'(100 * i);
            1:       return DATA_W'(3000 - 100 * i);
            2:       return DATA_W'(50 * i);
            3:       return (i < 48) ? DATA_W'(i) : DATA_W'(6000 + i - 48);
            default: return DATA_W'($urandom_range(0, 16383));
        endcase
    endfunction

    // Arms with RD_EN also high, so re-arming from DONE exercises ARM priority.
    task automatic run_capture(input int pre_v, input int lvl, input bit edge_v, input int kind);
        bit f;
        bit r;
        bit a;
        PRE_TRIG   = ADDR_W'(pre_v);
        TRIG_LEVEL = DATA_W'(lvl);
        TRIG_EDGE  = edge_v;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, gen_data(4, 0));
        for (int i = 0; i < 400 && !CAP_DONE; i++) begin
            f = (kind == 2) ? (i == 15) : (kind == 4) ? ($urandom_range(0, 39) == 0) : 1'b0;
            r = (kind == 3) && (i < 48);
            a = (kind == 3) && (i == 50 || i == 51);
            applyStimulus(1'b0, a, f, r, gen_data(kind, i));
        end
        check("done_timeout", 32'(CAP_DONE), 32'd1);
    endtask

    task automatic readout(input int n, input bit rand_en);
        read_log.delete();
        last_idx = -1;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, rand_en ? ($urandom_range(0, 9) < 7) : 1'b1,
                          DATA_W'($urandom_range(0, 16383)));
        end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        m_phase    = M_IDLE;
        m_trig     = 1'b0;
        exp_rdata  = 0;
        ADC_RST    = 1'b1;
        ARM        = 1'b0;
        FORCE_TRIG = 1'b0;
        RD_EN      = 1'b0;
        ADC_DATA   = '0;
        TRIG_LEVEL = '0;
        TRIG_EDGE  = 1'b0;
        PRE_TRIG   = '0;

        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("reset_busy", 32'(CAP_BUSY), 32'd0);
        check("reset_done", 32'(CAP_DONE), 32'd0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);

        $display("[TB] rising trigger, P=4");
        run_capture(4, 1000, 1'b0, 0);
        readout(16, 1'b0);
        check("rise_count", read_log.size(), 16);
        check("rise_first", read_log[0], 600);
        check("rise_trig", read_log[4], 1000);
        check("rise_last", read_log[15], 2100);
        check("rise_last_idx", last_idx, 15);
        check("rise_triggered", 32'(TRIGGERED), 32'd1);

        $display("[TB] falling trigger, P=0");
        run_capture(0, 2000, 1'b1, 1);
        readout(20, 1'b0);
        check("fall_first", read_log[0], 1900);
        check("fall_last", read_log[15], 400);
        check("fall_reread", read_log[16], 1900);

        $display("[TB] forced trigger, P=15");
        run_capture(15, 16000, 1'b0, 2);
        readout(16, 1'b0);
        check("force_first", read_log[0], 0);
        check("force_idx15", read_log[15], 750);
        check("force_last_idx", last_idx, 15);

        $display("[TB] wrap-around, P=8, ignored ARM/RD_EN");
        run_capture(8, 5000, 1'b0, 3);
        readout(16, 1'b0);
        check("wrap_first", read_log[0], 40);
        check("wrap_pre_end", read_log[7], 47);
        check("wrap_trig", read_log[8], 6000);
        check("wrap_last", read_log[15], 6007);

        $display("[TB] reset during post-trigger");
        PRE_TRIG = 4'd2;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, '0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, i == 2, 1'b0, DATA_W'(i));
        check("mid_busy", 32'(CAP_BUSY), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("rst_busy", 32'(CAP_BUSY), 32'd0);
        check("rst_trig", 32'(TRIGGERED), 32'd0);
        check("rst_rdata", 32'(RD_DATA), 32'd0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
        run_capture(4, 1000, 1'b0, 0);
        readout(16, 1'b0);
        check("post_rst_first", read_log[0], 600);

        $display("[TB] randomized captures");
        for (int t = 0; t < 12; t++) begin
            run_capture($urandom_range(0, 15), $urandom_range(1, 16383), 1'($urandom_range(0, 1)), 4);
            readout(40, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
